// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit FIFO and its launch sequencer.
package uart_pkg;

   // Width of one UART payload byte.
   localparam int unsigned UART_DATA_W    = 8;

   // Number of cycles spent in WAIT_HI before a launch is treated as lost.
   localparam int unsigned LAUNCH_TIMEOUT = 4;

   // Width of the lost-launch cycle counter (counts 0..LAUNCH_TIMEOUT-1).
   localparam int unsigned TMO_W          = $clog2(LAUNCH_TIMEOUT);

   // Launch sequencer states.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LAUNCH  = 2'd1,
      WAIT_HI = 2'd2,
      WAIT_LO = 2'd3
   } tx_state_e;

endpackage : uart_pkg

// File: rtl/uart_tx_fifo_if.sv
// CPU-write, status and serializer handshake signals of the UART transmit FIFO.
interface uart_tx_fifo_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 4
);

   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              ovf_clr;
   logic              full;
   logic              empty;
   logic [ADDR_W:0]   level;
   logic              overflow;
   logic              tx_start;
   logic [DATA_W-1:0] tx_data;
   logic              tx_busy;
   logic              sending;

   // Bus side: the APB write path and the uart_tx serializer.
   modport master (
      output wr_en,
      output wr_data,
      output ovf_clr,
      output tx_busy,
      input  full,
      input  empty,
      input  level,
      input  overflow,
      input  tx_start,
      input  tx_data,
      input  sending
   );

   // FIFO side: the uart_tx_fifo block itself.
   modport slave (
      input  wr_en,
      input  wr_data,
      input  ovf_clr,
      input  tx_busy,
      output full,
      output empty,
      output level,
      output overflow,
      output tx_start,
      output tx_data,
      output sending
   );

endinterface : uart_tx_fifo_if

// File: rtl/sync_fifo.sv
// Byte FIFO: register storage, wrapping pointers, level counter, full/empty and sticky overflow.
module sync_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = UART_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              rd_en_i,
   input  logic              ovf_clr_i,
   output logic [DATA_W-1:0] rd_data_c_o,
   output logic              full_o,
   output logic              empty_o,
   output logic [ADDR_W:0]   level_o,
   output logic              overflow_o
);

   localparam int unsigned LVL_W = ADDR_W + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]  level_q, level_d;
   logic              full_q, full_d;
   logic              empty_q, empty_d;
   logic              ovf_q, ovf_d;
   logic              push_c;
   logic              pop_c;

   // Next-state for pointers, level, flags; a push while full is refused even alongside a pop.
   always_comb begin
      push_c   = wr_en_i && !full_q;
      pop_c    = rd_en_i && !empty_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      ovf_d    = ovf_q;

      if (push_c) begin
         wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end
      if (pop_c) begin
         rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      end

      case ({push_c, pop_c})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase

      // Overflow set has priority over a same-cycle clear.
      if (wr_en_i && full_q) begin
         ovf_d = 1'b1;
      end else if (ovf_clr_i) begin
         ovf_d = 1'b0;
      end

      full_d  = (level_d == LVL_W'(DEPTH));
      empty_d = (level_d == '0);
   end

   // Pointer, level and flag registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage write; contents need no reset since level gates every read.
   always_ff @(posedge clk) begin
      if (!reset && push_c) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

   assign rd_data_c_o = mem_q[rd_ptr_q];
   assign full_o      = full_q;
   assign empty_o     = empty_q;
   assign level_o     = level_q;
   assign overflow_o  = ovf_q;

endmodule : sync_fifo

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO plus launch sequencer feeding one byte at a time to the uart_tx serializer.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = UART_DATA_W
) (
   input  logic           clk,
   input  logic           reset,
   uart_tx_fifo_if.slave  tx_if
);

   tx_state_e         state_q, state_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic              tx_start_q, tx_start_d;
   logic [DATA_W-1:0] tx_data_q, tx_data_d;
   logic              sending_q, sending_d;
   logic              pop_c;
   logic [DATA_W-1:0] fifo_rd_data_c;
   logic              fifo_full;
   logic              fifo_empty;
   logic [ADDR_W:0]   fifo_level;
   logic              fifo_ovf;

   sync_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .wr_en_i     (tx_if.wr_en),
      .wr_data_i   (tx_if.wr_data),
      .rd_en_i     (pop_c),
      .ovf_clr_i   (tx_if.ovf_clr),
      .rd_data_c_o (fifo_rd_data_c),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .level_o     (fifo_level),
      .overflow_o  (fifo_ovf)
   );

   // Sequencer next-state: pop in IDLE, pulse in LAUNCH, then track the serializer's busy.
   always_comb begin
      state_d   = state_q;
      tmo_d     = tmo_q;
      tx_data_d = tx_data_q;
      pop_c     = 1'b0;

      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop_c     = 1'b1;
               tx_data_d = fifo_rd_data_c;
               state_d   = LAUNCH;
            end
         end
         LAUNCH: begin
            tmo_d   = '0;
            state_d = WAIT_HI;
         end
         WAIT_HI: begin
            // A launch the serializer never acknowledges is abandoned; the byte stays consumed.
            if (tx_if.tx_busy) begin
               state_d = WAIT_LO;
            end else if (tmo_q == TMO_W'(LAUNCH_TIMEOUT - 1)) begin
               state_d = IDLE;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         WAIT_LO: begin
            if (!tx_if.tx_busy) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      tx_start_d = (state_d == LAUNCH);
      sending_d  = (state_d != IDLE);
   end

   // Sequencer state and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         tmo_q      <= '0;
         tx_start_q <= 1'b0;
         tx_data_q  <= '0;
         sending_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         tmo_q      <= tmo_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
         sending_q  <= sending_d;
      end
   end

   assign tx_if.tx_start = tx_start_q;
   assign tx_if.tx_data  = tx_data_q;
   assign tx_if.sending  = sending_q;
   assign tx_if.full     = fifo_full;
   assign tx_if.empty    = fifo_empty;
   assign tx_if.level    = fifo_level;
   assign tx_if.overflow = fifo_ovf;

endmodule : uart_tx_fifo

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: launch latency, fill/overflow, FIFO order across wrap, lost launch, reset.
module tb_uart_tx_fifo;

   localparam int unsigned DEPTH  = 16;
   localparam int unsigned ADDR_W = 4;
   localparam int unsigned DATA_W = 8;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   int   pulses;

   uart_tx_fifo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   uart_tx_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .tx_if (bus)
   );

   always #5 clk = ~clk;

   // Advance one clock and sample just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Wait a bounded number of cycles for a launch pulse.
   task automatic wait_start(input string tag, input int budget);
      int n;
      n = 0;
      while (bus.tx_start !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      chk(tag, 32'(bus.tx_start), 32'd1);
   endtask

   // Model serializer frame: busy for three cycles after a launch.
   task automatic frame();
      bus.tx_busy = 1'b1;
      repeat (3) tick();
      bus.tx_busy = 1'b0;
   endtask

   initial begin
      reset       = 1'b1;
      bus.wr_en   = 1'b0;
      bus.wr_data = '0;
      bus.ovf_clr = 1'b0;
      bus.tx_busy = 1'b0;
      tick();
      tick();

      // Reset state
      chk("rst_level",    32'(bus.level),    32'd0);
      chk("rst_empty",    32'(bus.empty),    32'd1);
      chk("rst_full",     32'(bus.full),     32'd0);
      chk("rst_overflow", 32'(bus.overflow), 32'd0);
      chk("rst_tx_start", 32'(bus.tx_start), 32'd0);
      chk("rst_tx_data",  32'(bus.tx_data),  32'd0);
      chk("rst_sending",  32'(bus.sending),  32'd0);
      reset = 1'b0;

      // Single byte: push, pop one cycle later, pulse the cycle after that
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'hA5;
      tick();
      bus.wr_en = 1'b0;
      chk("t1_level_after_push", 32'(bus.level),    32'd1);
      chk("t1_no_start_yet",     32'(bus.tx_start), 32'd0);
      tick();
      chk("t1_start",   32'(bus.tx_start), 32'd1);
      chk("t1_data",    32'(bus.tx_data),  32'hA5);
      chk("t1_level0",  32'(bus.level),    32'd0);
      chk("t1_sending", 32'(bus.sending),  32'd1);
      bus.tx_busy = 1'b1;
      pulses = 0;
      repeat (20) begin
         tick();
         if (bus.tx_start === 1'b1) pulses++;
      end
      chk("t1_extra_pulses", 32'(pulses),      32'd0);
      chk("t1_sending_busy", 32'(bus.sending), 32'd1);
      bus.tx_busy = 1'b0;
      tick();
      chk("t1_sending_drop", 32'(bus.sending), 32'd0);
      chk("t1_empty",        32'(bus.empty),   32'd1);

      // Fill while the serializer is busy: byte 0 pops, 15 remain, then fill and overflow
      bus.tx_busy = 1'b1;
      for (int i = 0; i < 16; i++) begin
         bus.wr_en   = 1'b1;
         bus.wr_data = 8'(i);
         tick();
      end
      chk("t2_level15",  32'(bus.level),   32'd15);
      chk("t2_not_full", 32'(bus.full),    32'd0);
      chk("t2_data0",    32'(bus.tx_data), 32'h00);
      bus.wr_data = 8'h10;
      tick();
      chk("t2_full",    32'(bus.full),  32'd1);
      chk("t2_level16", 32'(bus.level), 32'd16);
      bus.wr_data = 8'h11;
      tick();
      bus.wr_en = 1'b0;
      chk("t2_overflow",    32'(bus.overflow), 32'd1);
      chk("t2_level_held",  32'(bus.level),    32'd16);
      tick();
      tick();
      chk("t2_ovf_sticky",  32'(bus.overflow), 32'd1);
      bus.ovf_clr = 1'b1;
      tick();
      bus.ovf_clr = 1'b0;
      chk("t2_ovf_cleared", 32'(bus.overflow), 32'd0);

      // Release byte 0; in IDLE with a full FIFO, pop and a refused push share one cycle
      bus.tx_busy = 1'b0;
      tick();
      chk("t4_idle_full", 32'(bus.full),    32'd1);
      chk("t4_idle",      32'(bus.sending), 32'd0);
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'hEE;
      tick();
      bus.wr_en = 1'b0;
      chk("t4_level15", 32'(bus.level),    32'd15);
      chk("t4_ovf",     32'(bus.overflow), 32'd1);
      chk("t4_not_full",32'(bus.full),     32'd0);
      chk("t4_start",   32'(bus.tx_start), 32'd1);
      chk("t4_data1",   32'(bus.tx_data),  32'h01);
      frame();

      // Drain the rest in order across the pointer wrap
      for (int k = 2; k <= 16; k++) begin
         wait_start("t3_launch", 20);
         chk("t3_data", 32'(bus.tx_data), 32'(k));
         frame();
      end
      tick();
      tick();
      chk("t3_data_hold",  32'(bus.tx_data),  32'h10);
      chk("t3_level0",     32'(bus.level),    32'd0);
      chk("t3_empty",      32'(bus.empty),    32'd1);
      chk("t3_sending0",   32'(bus.sending),  32'd0);
      chk("t3_ovf_sticky", 32'(bus.overflow), 32'd1);
      bus.ovf_clr = 1'b1;
      tick();
      bus.ovf_clr = 1'b0;
      chk("t3_ovf_cleared", 32'(bus.overflow), 32'd0);

      // Lost launch: tx_busy never rises, sequencer gives up after four WAIT_HI cycles
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'h5A;
      tick();
      bus.wr_data = 8'h6B;
      tick();
      bus.wr_en = 1'b0;
      chk("t5_start1", 32'(bus.tx_start), 32'd1);
      chk("t5_data1",  32'(bus.tx_data),  32'h5A);
      repeat (4) tick();
      chk("t5_no_start",    32'(bus.tx_start), 32'd0);
      chk("t5_still_wait",  32'(bus.sending),  32'd1);
      tick();
      chk("t5_timeout_idle",32'(bus.sending),  32'd0);
      tick();
      chk("t5_relaunch",    32'(bus.tx_start), 32'd1);
      chk("t5_data2",       32'(bus.tx_data),  32'h6B);
      repeat (5) tick();
      chk("t5_idle2",       32'(bus.sending),  32'd0);
      chk("t5_level0",      32'(bus.level),    32'd0);

      // Reset in WAIT_LO with five bytes queued
      bus.tx_busy = 1'b1;
      for (int i = 0; i < 6; i++) begin
         bus.wr_en   = 1'b1;
         bus.wr_data = 8'(8'h30 + i);
         tick();
      end
      bus.wr_en = 1'b0;
      chk("t6_level5",  32'(bus.level),   32'd5);
      chk("t6_sending", 32'(bus.sending), 32'd1);
      chk("t6_data",    32'(bus.tx_data), 32'h30);
      reset = 1'b1;
      tick();
      chk("t6_rst_level",    32'(bus.level),    32'd0);
      chk("t6_rst_empty",    32'(bus.empty),    32'd1);
      chk("t6_rst_tx_start", 32'(bus.tx_start), 32'd0);
      chk("t6_rst_sending",  32'(bus.sending),  32'd0);
      chk("t6_rst_tx_data",  32'(bus.tx_data),  32'd0);
      reset = 1'b0;
      repeat (3) tick();
      bus.tx_busy = 1'b0;
      pulses = 0;
      repeat (12) begin
         tick();
         if (bus.tx_start === 1'b1) pulses++;
      end
      chk("t6_no_launch", 32'(pulses),    32'd0);
      chk("t6_empty",     32'(bus.empty), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global time bound.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_uart_tx_fifo
